// File: rtl/audio_adc_rx.sv
// I2S capture: codec ADC serial stream -> {left,right} pairs in a small FIFO.
// Define AUDIO_RX_PEAK_EN to build the peak magnitude meters.
module audio_adc_rx #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       aud_bclk,
  input  logic                       aud_adclrck,
  input  logic                       aud_adcdat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [DATA_W-2:0]          peak_l,
  output logic [DATA_W-2:0]          peak_r,
  input  logic                       peak_clr
);

  localparam int CW = $clog2(DATA_W);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {SYNC, DELAY, SHIFT, PAD} st_t;

  logic [2:0]          r_bclk_s;
  logic [2:0]          r_lrck_s;
  logic [1:0]          r_dat_s;
  logic                w_bclk_rise;
  logic                w_lr_edge;
  logic                w_lr;
  logic                w_dat;

  st_t                 r_st;
  st_t                 w_st_nxt;
  logic                w_restart;
  logic                w_shift;
  logic                w_latch;
  logic                w_last;

  logic [DATA_W-1:0]   r_sh;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_bitsel;
  logic                r_ch;
  logic [DATA_W-1:0]   r_left;
  logic [DATA_W-1:0]   w_word;
  logic [2*DATA_W-1:0] r_pair;
  logic                r_pair_vld;

  logic [2*DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wp;
  logic [AW-1:0]       r_rp;
  logic [AW:0]         r_fill;
  logic                r_ovf;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bclk_s <= '0;
      r_lrck_s <= '0;
      r_dat_s  <= '0;
    end else begin
      r_bclk_s <= {r_bclk_s[1:0], aud_bclk};
      r_lrck_s <= {r_lrck_s[1:0], aud_adclrck};
      r_dat_s  <= {r_dat_s[0], aud_adcdat};
    end
  end

  assign w_bclk_rise = r_bclk_s[1] & ~r_bclk_s[2];
  assign w_lr_edge   = r_lrck_s[1] ^ r_lrck_s[2];
  assign w_lr        = r_lrck_s[1];
  assign w_dat       = r_dat_s[1];

  always_ff @(posedge clk) begin
    if (reset) r_st <= SYNC;
    else       r_st <= w_st_nxt;
  end

  // lrck moves on bclk fall, so its edge is seen before the delay-bit rise
  always_comb begin
    w_st_nxt  = r_st;
    w_restart = 1'b0;
    w_shift   = 1'b0;
    w_latch   = 1'b0;
    w_last    = 1'b0;
    unique case (r_st)
      SYNC: begin
        if (w_lr_edge && !w_lr) begin
          w_st_nxt  = DELAY;
          w_restart = 1'b1;
        end
      end
      DELAY: begin
        if (w_lr_edge) begin
          w_restart = 1'b1;
        end else if (w_bclk_rise) begin
          w_st_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_lr_edge) begin
          w_latch   = 1'b1;
          w_restart = 1'b1;
          w_st_nxt  = DELAY;
        end else if (w_bclk_rise) begin
          w_shift = 1'b1;
          if (r_cnt == CW'(DATA_W-1)) begin
            w_latch  = 1'b1;
            w_last   = 1'b1;
            w_st_nxt = PAD;
          end
        end
      end
      PAD: begin
        if (w_lr_edge) begin
          w_restart = 1'b1;
          w_st_nxt  = DELAY;
        end
      end
      default: w_st_nxt = SYNC;
    endcase
  end

  assign w_bitsel = CW'(DATA_W-1) - r_cnt;
  assign w_word   = w_last ? (r_sh | {{(DATA_W-1){1'b0}}, w_dat}) : r_sh;

  // bits land at their final position so a short slot leaves zero LSBs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh       <= '0;
      r_cnt      <= '0;
      r_ch       <= 1'b0;
      r_left     <= '0;
      r_pair     <= '0;
      r_pair_vld <= 1'b0;
    end else begin
      r_pair_vld <= 1'b0;
      if (w_latch) begin
        if (r_ch) begin
          r_pair     <= {r_left, w_word};
          r_pair_vld <= 1'b1;
        end else begin
          r_left <= w_word;
        end
      end
      if (w_restart) begin
        r_sh  <= '0;
        r_cnt <= '0;
        r_ch  <= w_lr;
      end else if (w_shift) begin
        r_sh[w_bitsel] <= w_dat;
        r_cnt          <= r_cnt + CW'(1);
      end
    end
  end

  assign out_valid = (r_fill != '0);
  assign w_full    = (r_fill == (AW+1)'(DEPTH));
  assign w_pop     = out_valid && out_ready;
  assign w_push    = r_pair_vld && (!w_full || w_pop);
  assign w_drop    = r_pair_vld && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_fill <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= r_pair;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)      r_fill <= r_fill + (AW+1)'(1);
      else if (w_pop && !w_push) r_fill <= r_fill - (AW+1)'(1);
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign out_data = r_mem[r_rp];
  assign fill     = r_fill;
  assign overflow = r_ovf;

`ifdef AUDIO_RX_PEAK_EN
  logic              r_pk_vld;
  logic              r_pk_ch;
  logic [DATA_W-1:0] r_pk_word;
  logic [DATA_W-2:0] w_mag;
  logic [DATA_W-2:0] r_peak_l;
  logic [DATA_W-2:0] r_peak_r;
  logic              w_upd_l;
  logic              w_upd_r;

  // most negative code saturates to the largest positive magnitude
  always_comb begin
    w_mag = r_pk_word[DATA_W-2:0];
    if (r_pk_word[DATA_W-1]) begin
      if (r_pk_word[DATA_W-2:0] == '0) w_mag = '1;
      else w_mag = ~r_pk_word[DATA_W-2:0] + (DATA_W-1)'(1);
    end
  end

  assign w_upd_l = r_pk_vld && !r_pk_ch;
  assign w_upd_r = r_pk_vld && r_pk_ch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pk_vld  <= 1'b0;
      r_pk_ch   <= 1'b0;
      r_pk_word <= '0;
      r_peak_l  <= '0;
      r_peak_r  <= '0;
    end else begin
      r_pk_vld <= w_latch;
      if (w_latch) begin
        r_pk_word <= w_word;
        r_pk_ch   <= r_ch;
      end
      if (peak_clr) begin
        r_peak_l <= w_upd_l ? w_mag : '0;
        r_peak_r <= w_upd_r ? w_mag : '0;
      end else begin
        if (w_upd_l && w_mag > r_peak_l) r_peak_l <= w_mag;
        if (w_upd_r && w_mag > r_peak_r) r_peak_r <= w_mag;
      end
    end
  end

  assign peak_l = r_peak_l;
  assign peak_r = r_peak_r;
`else
  logic w_unused_peak;
  assign w_unused_peak = peak_clr;
  assign peak_l = '0;
  assign peak_r = '0;
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// Scoreboard bench for audio_adc_rx: I2S codec model drives frames,
// expected pairs are queued and popped as the FIFO delivers them.
module tb_audio_adc_rx;

  localparam int DW  = 16;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          aud_bclk;
  logic          aud_adclrck;
  logic          aud_adcdat;
  logic          out_valid;
  logic          out_ready;
  logic [2*DW-1:0] out_data;
  logic [2:0]    fill;
  logic          overflow;
  logic          ovf_clr;
  logic [DW-2:0] peak_l;
  logic [DW-2:0] peak_r;
  logic          peak_clr;

  int total = 0;
  int bad   = 0;
  logic [31:0] q[$];

  audio_adc_rx #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset),
    .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck),
    .aud_adcdat(aud_adcdat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .fill(fill),
    .overflow(overflow), .ovf_clr(ovf_clr),
    .peak_l(peak_l), .peak_r(peak_r), .peak_clr(peak_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic bhalf(input logic lvl, input logic lr,
                       input logic d);
    repeat (4) @(posedge clk);
    #3;
    aud_bclk = lvl;
    if (!lvl) begin
      aud_adclrck = lr;
      aud_adcdat  = d;
    end
  endtask

  task automatic bper(input logic lr, input logic d);
    bhalf(1'b0, lr, d);
    bhalf(1'b1, lr, d);
  endtask

  // one slot: delay bit, then nb bits taken MSB-first from bits
  task automatic slot(input logic lr, input logic [31:0] bits,
                      input int nb);
    bper(lr, 1'b0);
    for (int i = 0; i < nb; i++) bper(lr, bits[31-i]);
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r,
                       input int nb, input logic [15:0] ext);
    slot(1'b0, {l, ext}, nb);
    slot(1'b1, {r, ext}, nb);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    aud_bclk    = 1'b1;
    aud_adclrck = 1'b1;
    aud_adcdat  = 1'b0;
    out_ready   = 1'b0;
    ovf_clr     = 1'b0;
    peak_clr    = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
  endtask

  task automatic drain(input int n);
    int got = 0;
    int guard = 0;
    logic [31:0] exp;
    @(negedge clk);
    out_ready = 1'b1;
    while (got < n && guard < 400) begin
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL drain_extra: got %h, expected nothing", out_data);
        end else begin
          exp = q.pop_front();
          if (out_data !== exp) begin
            bad++;
            $display("FAIL drain_data: got %h, expected %h", out_data, exp);
          end
        end
        got++;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    if (got < n) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pairs, expected %0d", got, n);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty: out_valid %b, expected 0", out_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: %b vs 0", out_valid); end
    if (out_data !== 32'h0) begin bad++; $display("FAIL rst_data: %h vs 0", out_data); end
    if (fill !== 3'd0) begin bad++; $display("FAIL rst_fill: %0d vs 0", fill); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: %b vs 0", overflow); end
    if (peak_l !== 15'h0 || peak_r !== 15'h0) begin
      bad++; $display("FAIL rst_peak: %h/%h vs 0", peak_l, peak_r);
    end
    slot(1'b0, {16'h1234, 16'h0}, 8);
    do_reset();
    slot(1'b1, {16'hABCD, 16'h0}, 16);
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++;
    if (fill !== 3'd0) begin bad++; $display("FAIL rst_midframe: fill %0d vs 0", fill); end
  endtask

  task automatic test_basic();
    do_reset();
    slot(1'b0, {16'h8001, 16'h0}, 16);
    slot(1'b1, {16'h7FFE, 16'h0}, 16);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early: valid %b vs 0", out_valid); end
    @(posedge clk);
    @(negedge clk);
    total += 2;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid: valid %b vs 1", out_valid); end
    if (fill !== 3'd1) begin bad++; $display("FAIL basic_fill: %0d vs 1", fill); end
    q.push_back(32'h8001_7FFE);
    drain(1);
  endtask

  task automatic test_midslot();
    do_reset();
    slot(1'b1, {16'h5555, 16'h0}, 6);
    frame(16'h1111, 16'h2222, 16, 16'h0);
    q.push_back(32'h1111_2222);
    frame(16'h3333, 16'h4444, 16, 16'h0);
    q.push_back(32'h3333_4444);
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++;
    if (fill !== 3'd2) begin bad++; $display("FAIL mid_fill: %0d vs 2", fill); end
    drain(2);
  endtask

  task automatic test_overflow();
    logic [15:0] v;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v = 16'h1010 * 16'(i + 1);
      frame(v, ~v, 16, 16'h0);
      if (i < 4) q.push_back({v, ~v});
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    total += 3;
    if (fill !== 3'd4) begin bad++; $display("FAIL ovf_fill: %0d vs 4", fill); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: %b vs 1", overflow); end
    if (out_data !== q[0]) begin bad++; $display("FAIL ovf_head: %h vs %h", out_data, q[0]); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: %b vs 0", overflow); end
    drain(4);
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = 16'h0F0F + 16'(i * 3);
      frame(v, 16'(i), 16, 16'h0);
      q.push_back({v, 16'(i)});
    end
    slot(1'b0, {16'hBEEF, 16'h0}, 16);
    slot(1'b1, {16'hCAFE, 16'h0}, 16);
    q.push_back(32'hBEEF_CAFE);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    exp = q.pop_front();
    total += 2;
    if (fill !== 3'd4) begin bad++; $display("FAIL b2b_full: %0d vs 4", fill); end
    if (out_data !== exp) begin bad++; $display("FAIL b2b_head: %h vs %h", out_data, exp); end
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    total += 2;
    if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf: %b vs 0", overflow); end
    if (fill !== 3'd4) begin bad++; $display("FAIL b2b_fill: %0d vs 4", fill); end
    drain(4);
  endtask

  task automatic test_slot_width();
    do_reset();
    frame(16'hC3A5, 16'h5A3C, 24, 16'hFFFF);
    q.push_back(32'hC3A5_5A3C);
    slot(1'b0, {16'hABCD, 16'hFFFF}, 12);
    slot(1'b1, {16'h1357, 16'hFFFF}, 12);
    slot(1'b0, 32'h0, 1);
    q.push_back(32'hABC0_1350);
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++;
    if (fill !== 3'd2) begin bad++; $display("FAIL width_fill: %0d vs 2", fill); end
    drain(2);
  endtask

  task automatic test_peak();
    logic [15:0] ls [3];
    logic [14:0] el [3];
    logic [14:0] er;
    ls[0] = 16'h0100;
    ls[1] = 16'hFE00;
    ls[2] = 16'h8000;
`ifdef AUDIO_RX_PEAK_EN
    el[0] = 15'h0100;
    el[1] = 15'h0200;
    el[2] = 15'h7FFF;
    er    = 15'h0010;
`else
    el[0] = 15'h0;
    el[1] = 15'h0;
    el[2] = 15'h0;
    er    = 15'h0;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      frame(ls[i], 16'h0010, 16, 16'h0);
      q.push_back({ls[i], 16'h0010});
      repeat (4) @(posedge clk);
      @(negedge clk);
      total++;
      if (peak_l !== el[i]) begin bad++; $display("FAIL peak_l%0d: %h vs %h", i, peak_l, el[i]); end
    end
    total++;
    if (peak_r !== er) begin bad++; $display("FAIL peak_r: %h vs %h", peak_r, er); end
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    total++;
    if (peak_l !== 15'h0 || peak_r !== 15'h0) begin
      bad++; $display("FAIL peak_clr: %h/%h vs 0", peak_l, peak_r);
    end
    drain(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midslot();
    test_overflow();
    test_back_to_back();
    test_slot_width();
    test_peak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
